// File: rtl/seg_pkg.sv
// Shared constants for the two-digit segment display source.
// Segment bit map, hex pattern table and register layout.
package seg_pkg;

    localparam int SEG_A  = 11;
    localparam int SEG_B  = 10;
    localparam int SEG_C  = 9;
    localparam int SEG_D  = 8;
    localparam int SEG_E  = 6;
    localparam int SEG_F  = 4;
    localparam int SEG_G  = 3;
    localparam int SEG_DP = 2;

    localparam logic [11:0] DP_MASK = 12'h001 << SEG_DP;

    localparam logic [11:0] HEX_TAB [16] = '{
        12'hF50, 12'h600, 12'hD48, 12'hF08,
        12'h618, 12'hB18, 12'hB58, 12'hE00,
        12'hF58, 12'hF18, 12'hE58, 12'h358,
        12'h950, 12'h748, 12'h958, 12'h858
    };

    localparam int DATA_OFS = 0;
    localparam int CTRL_OFS = 1;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_BLINK = 1;
    localparam int CTRL_LZ    = 2;
    localparam int CTRL_DPL   = 3;
    localparam int CTRL_DPH   = 4;
    localparam int CTRL_W     = 5;

    localparam logic [CTRL_W-1:0] CTRL_RST = 5'b00001;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to 12-bit segment pattern decoder.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0]  nib_i,
    output logic [11:0] seg_o
);

    assign seg_o = HEX_TAB[nib_i];

endmodule

// File: rtl/seg_byte_source.sv
// CPU-writable byte display source feeding a two-digit segment mux.
// Holds DATA/CTRL, decodes both nibbles, applies blank/blink/dp.
module seg_byte_source
    import seg_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h4020,
    parameter int                CNT_W     = 24,
    parameter logic [CNT_W-1:0]  BLINK_DIV = 24'd6000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic [11:0]       low,
    output logic [11:0]       high
);

    localparam logic [ADDR_W-1:0] DATA_ADDR = BASE_ADDR + ADDR_W'(DATA_OFS);
    localparam logic [ADDR_W-1:0] CTRL_ADDR = BASE_ADDR + ADDR_W'(CTRL_OFS);
    localparam logic [CNT_W-1:0]  CNT_LAST  = BLINK_DIV - CNT_W'(1);

    logic [7:0]        data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              phase_q, phase_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic [11:0]       low_q, low_d;
    logic [11:0]       high_q, high_d;
    logic [11:0]       lo_dec, hi_dec;
    logic              cnt_wrap;
    logic              unused_wr_hi;

    assign unused_wr_hi = ^wr_data[7:CTRL_W];

    hex_to_seg u_lo (
        .nib_i (data_q[3:0]),
        .seg_o (lo_dec)
    );

    hex_to_seg u_hi (
        .nib_i (data_q[7:4]),
        .seg_o (hi_dec)
    );

    assign cnt_wrap = (cnt_q == CNT_LAST);

    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        if (wr_en && addr == DATA_ADDR) data_d = wr_data;
        if (wr_en && addr == CTRL_ADDR) ctrl_d = wr_data[CTRL_W-1:0];

        rd_data_d = rd_data_q;
        if (rd_en) begin
            unique case (1'b1)
                (addr == DATA_ADDR): rd_data_d = data_q;
                (addr == CTRL_ADDR): rd_data_d = {3'b000, ctrl_q};
                default:             rd_data_d = 8'h00;
            endcase
        end

        // Counter idles at zero so a fresh blink starts in the visible phase.
        cnt_d   = '0;
        phase_d = 1'b0;
        if (ctrl_q[CTRL_BLINK]) begin
            cnt_d   = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
            phase_d = phase_q ^ cnt_wrap;
        end

        low_d  = lo_dec;
        high_d = hi_dec;
        if (ctrl_q[CTRL_LZ] && data_q[7:4] == 4'h0) high_d = '0;
        if (ctrl_q[CTRL_DPL]) low_d  = low_d | DP_MASK;
        if (ctrl_q[CTRL_DPH]) high_d = high_d | DP_MASK;
        if (!ctrl_q[CTRL_EN] || (ctrl_q[CTRL_BLINK] && phase_q)) begin
            low_d  = '0;
            high_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q    <= 8'h00;
            ctrl_q    <= CTRL_RST;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            rd_data_q <= 8'h00;
            low_q     <= '0;
            high_q    <= '0;
        end else begin
            data_q    <= data_d;
            ctrl_q    <= ctrl_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            rd_data_q <= rd_data_d;
            low_q     <= low_d;
            high_q    <= high_d;
        end
    end

    assign rd_data = rd_data_q;
    assign low     = low_q;
    assign high    = high_q;

endmodule
